exe_stage_muldiv: RTL and testbench

// EXE stage datapath fed by the ID/EXE pipeline register; drives the EXE/MEM register.

---
 rtl/exe_stage_muldiv_if.sv | 29 ++
 rtl/exe_stage_muldiv.sv | 179 +++++++++++++++++
 tb/tb_exe_stage_muldiv.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/exe_stage_muldiv_if.sv
// ID/EXE -> EXE -> EXE/MEM signal bundle for the EXE stage with iterative MUL/DIV.
interface exe_stage_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic [3:0]       EXE_CMD;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic             WB_EN_IN;
  logic             MEM_R_EN_IN;
  logic             MEM_W_EN_IN;
  logic [WIDTH-1:0] ALU_result;
  logic             WB_EN;
  logic             MEM_R_EN;
  logic             MEM_W_EN;
  logic             md_stall;
  logic             md_busy;

  // Pipeline side: drives the ID/EXE fields, consumes the EXE/MEM fields and stall.
  modport master (
    output EXE_CMD, val1, val2, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN,
    input  ALU_result, WB_EN, MEM_R_EN, MEM_W_EN, md_stall, md_busy
  );

  // EXE stage side.
  modport slave (
    input  EXE_CMD, val1, val2, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN,
    output ALU_result, WB_EN, MEM_R_EN, MEM_W_EN, md_stall, md_busy
  );
endinterface

// File: rtl/exe_stage_muldiv.sv
// EXE stage: combinational ALU plus a one-bit-per-cycle shift-add multiplier and
// restoring divider. While MUL/DIV iterates the front end is stalled and a bubble
// is sent to EXE/MEM.
module exe_stage_muldiv #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_MD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  exe_stage_muldiv_if.slave bus
);
  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [3:0] CmdAdd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAnd = 4'b0100;
  localparam logic [3:0] CmdOr  = 4'b0101;
  localparam logic [3:0] CmdNor = 4'b0110;
  localparam logic [3:0] CmdXor = 4'b0111;
  localparam logic [3:0] CmdSll = 4'b1000;
  localparam logic [3:0] CmdSra = 4'b1001;
  localparam logic [3:0] CmdSrl = 4'b1010;
  localparam logic [3:0] CmdMul = 4'b1100;
  localparam logic [3:0] CmdDiv = 4'b1101;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // a: multiplicand (MUL) or dividend shifting into quotient (DIV)
  // b: multiplier (MUL) or divisor (DIV); acc: product (MUL) or remainder (DIV)
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic             neg_q, neg_d, div_q, div_d, div0_q, div0_d;

  logic [WIDTH-1:0] alu_res;
  logic [ShW-1:0]   shamt;
  logic             is_md;
  logic             neg1, neg2;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   div_sh, div_diff;
  logic             qbit;
  logic [WIDTH-1:0] div_rem, div_quo, raw, fixed;

  assign shamt = bus.val2[ShW-1:0];
  assign is_md = (bus.EXE_CMD == CmdMul) || (bus.EXE_CMD == CmdDiv);
  assign neg1  = SIGNED_MD && bus.val1[WIDTH-1];
  assign neg2  = SIGNED_MD && bus.val2[WIDTH-1];
  assign abs1  = neg1 ? -bus.val1 : bus.val1;
  assign abs2  = neg2 ? -bus.val2 : bus.val2;

  // Single-cycle ALU operations.
  always_comb begin
    alu_res = '0;
    case (bus.EXE_CMD)
      CmdAdd:  alu_res = bus.val1 + bus.val2;
      CmdSub:  alu_res = bus.val1 - bus.val2;
      CmdAnd:  alu_res = bus.val1 & bus.val2;
      CmdOr:   alu_res = bus.val1 | bus.val2;
      CmdNor:  alu_res = ~(bus.val1 | bus.val2);
      CmdXor:  alu_res = bus.val1 ^ bus.val2;
      CmdSll:  alu_res = bus.val1 << shamt;
      CmdSra:  alu_res = $signed(bus.val1) >>> shamt;
      CmdSrl:  alu_res = bus.val1 >> shamt;
      default: alu_res = '0;
    endcase
  end

  // One iteration of each algorithm, plus sign/divide-by-zero correction of the final step.
  always_comb begin
    mul_acc  = acc_q + (b_q[0] ? a_q : '0);
    div_sh   = {acc_q, a_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    qbit     = ~div_diff[WIDTH];
    div_rem  = qbit ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_quo  = {a_q[WIDTH-2:0], qbit};
    raw      = div_q ? div_quo : mul_acc;
    if (div_q && div0_q) begin
      fixed = '1;
    end else if (neg_q) begin
      fixed = -raw;
    end else begin
      fixed = raw;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      div_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      div_q   <= div_d;
      div0_q  <= div0_d;
    end
  end

  // Next state, datapath updates and stage outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    a_d            = a_q;
    b_d            = b_q;
    acc_d          = acc_q;
    res_d          = res_q;
    neg_d          = neg_q;
    div_d          = div_q;
    div0_d         = div0_q;
    bus.ALU_result = '0;
    bus.WB_EN      = 1'b0;
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.md_stall   = 1'b0;
    bus.md_busy    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_md) begin
          // Gated by rst so a MUL/DIV sitting in ID/EXE cannot raise stall during reset.
          if (rst) begin
            bus.md_stall = 1'b1;
            a_d          = abs1;
            b_d          = abs2;
            acc_d        = '0;
            neg_d        = neg1 ^ neg2;
            div_d        = (bus.EXE_CMD == CmdDiv);
            div0_d       = (bus.val2 == '0);
            cnt_d        = '0;
            state_d      = StBusy;
          end
        end else begin
          bus.ALU_result = alu_res;
          bus.WB_EN      = bus.WB_EN_IN;
          bus.MEM_R_EN   = bus.MEM_R_EN_IN;
          bus.MEM_W_EN   = bus.MEM_W_EN_IN;
        end
      end
      StBusy: begin
        bus.md_stall = 1'b1;
        bus.md_busy  = 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (div_q) begin
          acc_d = div_rem;
          a_d   = div_quo;
        end else begin
          acc_d = mul_acc;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end
        if (cnt_q == CntW'(WIDTH - 1)) begin
          res_d   = fixed;
          state_d = StDone;
        end
      end
      StDone: begin
        bus.ALU_result = res_q;
        bus.WB_EN      = bus.WB_EN_IN;
        bus.MEM_R_EN   = bus.MEM_R_EN_IN;
        bus.MEM_W_EN   = bus.MEM_W_EN_IN;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end
endmodule

// File: tb/tb_exe_stage_muldiv.sv
// Directed bench for exe_stage_muldiv (WIDTH=32, signed MUL/DIV).
module tb_exe_stage_muldiv;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   wb_pulses;

  exe_stage_muldiv_if #(.WIDTH(32)) bus ();

  exe_stage_muldiv #(.WIDTH(32), .SIGNED_MD(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic wb, input logic mr, input logic mw);
    bus.EXE_CMD     = cmd;
    bus.val1        = v1;
    bus.val2        = v2;
    bus.WB_EN_IN    = wb;
    bus.MEM_R_EN_IN = mr;
    bus.MEM_W_EN_IN = mw;
  endtask

  // Issue one MUL/DIV at the next falling edge and follow it through to its DONE cycle.
  task automatic run_md(input string name, input logic [3:0] cmd, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] exp);
    int   stalls;
    logic bad;
    @(negedge clk);
    drive(cmd, v1, v2, 1'b1, 1'b0, 1'b1);
    stalls = 0;
    bad    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.md_stall) break;
      if (bus.WB_EN) wb_pulses++;
      if (bus.WB_EN || bus.MEM_W_EN || bus.MEM_R_EN || (bus.ALU_result != 32'd0) ||
          (bus.md_busy != (stalls != 0))) begin
        bad = 1'b1;
      end
      stalls++;
      @(negedge clk);
    end
    if (bus.WB_EN) wb_pulses++;
    check({name, " stall cycles"}, stalls, 32'd33);
    check({name, " bubble during stall"}, {31'd0, bad}, 32'd0);
    check({name, " result"}, bus.ALU_result, exp);
    check({name, " WB_EN in DONE"}, {31'd0, bus.WB_EN}, 32'd1);
    check({name, " MEM_W_EN in DONE"}, {31'd0, bus.MEM_W_EN}, 32'd1);
    check({name, " md_busy in DONE"}, {31'd0, bus.md_busy}, 32'd0);
  endtask

  initial begin
    int bad;
    n_cmp     = 0;
    n_err     = 0;
    wb_pulses = 0;

    vecs[0]  = '{4'b0000, 32'd5,          32'd7,          32'd12};
    vecs[1]  = '{4'b0010, 32'd5,          32'd7,          32'hFFFFFFFE};
    vecs[2]  = '{4'b0100, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200};
    vecs[3]  = '{4'b0101, 32'hF000_0001,  32'h0000_0F00,  32'hF000_0F01};
    vecs[4]  = '{4'b0110, 32'hF000_0001,  32'h0000_0F00,  32'h0FFF_F0FE};
    vecs[5]  = '{4'b0111, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555};
    vecs[6]  = '{4'b1000, 32'd1,          32'h0000_0024,  32'h0000_0010};
    vecs[7]  = '{4'b1001, 32'h8000_0000,  32'h0000_0021,  32'hC000_0000};
    vecs[8]  = '{4'b1010, 32'h8000_0000,  32'd4,          32'h0800_0000};
    vecs[9]  = '{4'b1111, 32'd123,        32'd456,        32'd0};
    vecs[10] = '{4'b0000, 32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[11] = '{4'b1001, 32'h7FFF_FFF0,  32'd4,          32'h07FF_FFFF};

    // Reset with a MUL sitting at the input: nothing may stall while rst is low.
    rst = 1'b0;
    drive(4'b1100, 32'd3, 32'd7, 1'b1, 1'b0, 1'b0);
    #12;
    check("reset md_stall", {31'd0, bus.md_stall}, 32'd0);
    check("reset md_busy", {31'd0, bus.md_busy}, 32'd0);
    check("reset WB_EN", {31'd0, bus.WB_EN}, 32'd0);
    @(negedge clk);
    drive(4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Combinational ALU table; control enables alternate to show pass-through.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].cmd, vecs[i].v1, vecs[i].v2, i[0], ~i[0], i[1]);
      #1;
      check($sformatf("alu vec %0d result", i), bus.ALU_result, vecs[i].exp);
      check($sformatf("alu vec %0d ctrl", i), {29'd0, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN},
            {29'd0, i[0], ~i[0], i[1]});
      check($sformatf("alu vec %0d stall", i), {31'd0, bus.md_stall}, 32'd0);
    end

    run_md("mul -3*7", 4'b1100, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
    run_md("mul -4*-5", 4'b1100, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'd20);
    run_md("mul wrap", 4'b1100, 32'h0001_0003, 32'h0001_0000, 32'h0003_0000);
    run_md("div 100/7", 4'b1101, 32'd100, 32'd7, 32'd14);
    run_md("div -100/7", 4'b1101, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    run_md("div 5/0", 4'b1101, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_md("div -5/0", 4'b1101, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run_md("div minneg/-1", 4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("div 7/-2", 4'b1101, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);

    // Back-to-back MULs: each gets its own full stall, exactly one WB_EN pulse each.
    wb_pulses = 0;
    run_md("b2b mul 1", 4'b1100, 32'd6, 32'd7, 32'd42);
    run_md("b2b mul 2", 4'b1100, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA);
    check("b2b WB_EN pulses", wb_pulses, 32'd2);

    // Reset in the middle of BUSY aborts the operation.
    @(negedge clk);
    drive(4'b1100, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1;
    check("pre-abort md_busy", {31'd0, bus.md_busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort md_stall", {31'd0, bus.md_stall}, 32'd0);
    check("abort md_busy", {31'd0, bus.md_busy}, 32'd0);
    check("abort WB_EN", {31'd0, bus.WB_EN}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0000, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
    #1;
    check("post-abort ADD", bus.ALU_result, 32'd12);
    check("post-abort stall", {31'd0, bus.md_stall}, 32'd0);
    check("post-abort WB_EN", {31'd0, bus.WB_EN}, 32'd1);
    @(negedge clk);
    drive(4'b1111, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.WB_EN || bus.md_stall || bus.md_busy) bad++;
      @(negedge clk);
    end
    check("no stray WB_EN/stall after abort", bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
